weighted_arbitration_unit: RTL and testbench
============================================

# weighted_arbitration_unit

Registered, weighted round-robin arbiter: the parametrised successor to the combinational round-robin arbitration unit. It grants one of `NUM_CLIENTS` requesters per cycle, lets each client keep the grant for up to a programmable number of consecutive cycles, and supports a fixed-priority mode and an optional hold. It sits between the shared-resource clients (hash cores, memory ports) and the resource mux, driving a one-hot select plus an encoded index.

## Interface
- `NUM_CLIENTS`, 8, number of requesters (≥2).
- `WEIGHT_W`, 4, bits per client weight.
- `CAN_HOLD`, 1, 1 = `hold` input honoured; 0 = `hold` ignored.
- `BIT_CLIENTS`, `$clog2(NUM_CLIENTS)`, derived localparam.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `requests`  in  NUM_CLIENTS  per-client request level.
- `weights`  in  NUM_CLIENTS*WEIGHT_W  client i weight at bits [i*WEIGHT_W +: WEIGHT_W].
- `prio_mode`  in  1  0 = weighted round-robin; 1 = fixed priority, lowest index wins.
- `hold`  in  1  freeze current grant.
- `grants`  out  NUM_CLIENTS  registered one-hot grant, or zero.
- `grant_idx`  out  BIT_CLIENTS  index of granted client.
- `grant_valid`  out  1  high when `grants` is non-zero.

## Operation
- State: `owner` (BIT_CLIENTS), `credit` (WEIGHT_W), and the output registers.
- Effective weight: w = weights[i]; a value of 0 is treated as 1. Client i keeps the grant for at most w consecutive non-held cycles.
- Each rising edge evaluates, in priority order:
  1. **Hold:** `CAN_HOLD`=1 and `hold`=1 and `grant_valid`=1 and `requests[owner]`=1 → outputs and `credit` unchanged.
  2. **Priority mode:** `prio_mode`=1 → grant the lowest-index requester. `owner` ← winner; `credit` ← w(winner)−1.
  3. **Continue tenure:** `grant_valid`=1 and `requests[owner]`=1 and `credit`>0 → keep owner; `credit` ← `credit`−1.
  4. **Arbitrate:** search `owner`+1, `owner`+2, … wrapping, ending at `owner` itself. The first requester wins. `owner` ← winner; `credit` ← w(winner)−1.
  5. **No requests:** `grants`=0, `grant_valid`=0, `grant_idx` holds its last value. `owner` is retained so round-robin fairness continues.
- Weights are sampled only when the credit is loaded; changing a weight mid-tenure has no effect until the next win.
- If the owner drops its request, it loses the grant at the next edge even with credit remaining. The next requester is found by the search in step 4.
- If only the owner requests and its credit is exhausted, the search wraps to the owner, which is re-granted with fresh credit.
- A hold with `grant_valid`=0 or with the owner not requesting has no effect.
- Invariants: `grants` is always one-hot or zero, and `grants[grant_idx]`==`grant_valid`.

## Timing
- Latency: `requests`, `hold`, `prio_mode` and `weights` sampled at edge t produce the grant visible after edge t (one-cycle registered). There is no combinational path from inputs to outputs.
- Reset (`rst_n` low, asynchronous, takes effect immediately):
  - `grants`=0, `grant_valid`=0, `grant_idx`=0.
  - `owner`=NUM_CLIENTS−1, so the first search starts at client 0.
  - `credit`=0.
- Reset asserted mid-tenure discards owner and credit.
- The first edge after reset release arbitrates normally.
- `prio_mode` toggles take effect at the next edge. Leaving priority mode continues round-robin from the current owner.

## Test plan
- **Equal weights:** all weights=1, `requests`=0000_0011 for 3 edges → `grants` 0000_0001, 0000_0010, 0000_0001.
- **Weighted tenure:** weight0=3, weight1=1 (0 treated as 1 elsewhere), `requests`=0000_0011 for 8 edges → grant index sequence 0,0,0,1,0,0,0,1.
- **Hold:** client 2 granted with weight 1, `requests`=0000_1100, `hold`=1 for 3 edges → `grants` stays 0000_0100. After `hold`=0 the next edge gives 0000_1000.
- **Early release:** weight0=4, client 0 granted; client 0 drops its request after 2 grants while `requests[5]`=1 → next edge `grants`=0010_0000 and `grant_idx`=5.
- **Priority mode:** `prio_mode`=1, `requests`=1000_0110 for 4 edges → `grants`=0000_0010 every edge. Then `requests`=0 → `grants`=0, `grant_valid`=0, `grant_idx`=1.
- **Reset mid-operation:** pull `rst_n` low between edges during a tenure → outputs go to 0 immediately. Release with `requests`=1111_1111 → first grant is 0000_0001.

Source files
------------

// File: rtl/weighted_arbitration_unit.sv
// rtl/weighted_arbitration_unit.sv - registered weighted round-robin arbiter with priority mode and hold
module weighted_arbitration_unit #(
    parameter  int NUM_CLIENTS = 8,
    parameter  int WEIGHT_W    = 4,
    parameter  int CAN_HOLD    = 1,
    localparam int BIT_CLIENTS = $clog2(NUM_CLIENTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CLIENTS-1:0]          requests,
    input  logic [NUM_CLIENTS*WEIGHT_W-1:0] weights,
    input  logic                            prio_mode,
    input  logic                            hold,
    output logic [NUM_CLIENTS-1:0]          grants,
    output logic [BIT_CLIENTS-1:0]          grant_idx,
    output logic                            grant_valid
);

    // Remaining extra cycles of tenure for a freshly loaded weight (0 behaves as 1).
    function automatic logic [WEIGHT_W-1:0] load_credit(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? '0 : w - WEIGHT_W'(1);
    endfunction

    logic [BIT_CLIENTS-1:0] owner, owner_n;
    logic [WEIGHT_W-1:0]    credit, credit_n;
    logic [NUM_CLIENTS-1:0] grants_n;
    logic [BIT_CLIENTS-1:0] grant_idx_n;
    logic                   grant_valid_n;

    logic [WEIGHT_W-1:0]    weight_arr [NUM_CLIENTS];
    logic                   any_req;
    logic [BIT_CLIENTS-1:0] prio_idx;
    logic [BIT_CLIENTS-1:0] rr_idx;
    logic                   hold_ok;
    logic                   take;
    logic [BIT_CLIENTS-1:0] win_idx;

    // Unpack the flat weight bus into one entry per client.
    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            weight_arr[i] = weights[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    // Fixed-priority winner: lowest requesting index (last assignment wins, so scan downward).
    always_comb begin
        prio_idx = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (requests[i]) begin
                prio_idx = BIT_CLIENTS'(i);
            end
        end
    end

    // Round-robin winner: first requester at owner+1, owner+2, ... wrapping back to owner.
    always_comb begin
        logic [BIT_CLIENTS-1:0] cand;
        rr_idx = owner;
        cand   = '0;
        for (int k = NUM_CLIENTS; k >= 1; k--) begin
            cand = BIT_CLIENTS'((int'(owner) + k) % NUM_CLIENTS);
            if (requests[cand]) begin
                rr_idx = cand;
            end
        end
    end

    assign any_req = |requests;
    assign hold_ok = (CAN_HOLD != 0) && hold && grant_valid && requests[owner];

    // Next-state selection in priority order: hold, priority mode, tenure, arbitrate, idle.
    always_comb begin
        owner_n       = owner;
        credit_n      = credit;
        grants_n      = grants;
        grant_idx_n   = grant_idx;
        grant_valid_n = grant_valid;
        take          = 1'b0;
        win_idx       = rr_idx;

        if (hold_ok) begin
            take = 1'b0;
        end else if (prio_mode) begin
            take    = any_req;
            win_idx = prio_idx;
        end else if (grant_valid && requests[owner] && (credit != '0)) begin
            credit_n = credit - WEIGHT_W'(1);
        end else begin
            take    = any_req;
            win_idx = rr_idx;
        end

        if (take) begin
            owner_n       = win_idx;
            credit_n      = load_credit(weight_arr[win_idx]);
            grants_n      = NUM_CLIENTS'(1) << win_idx;
            grant_idx_n   = win_idx;
            grant_valid_n = 1'b1;
        end else if (!hold_ok && !any_req) begin
            grants_n      = '0;
            grant_valid_n = 1'b0;
        end
    end

    // State and output registers; reset parks the owner at the last client so the first search starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= BIT_CLIENTS'(NUM_CLIENTS - 1);
            credit      <= '0;
            grants      <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            owner       <= owner_n;
            credit      <= credit_n;
            grants      <= grants_n;
            grant_idx   <= grant_idx_n;
            grant_valid <= grant_valid_n;
        end
    end

endmodule

// File: tb/tb_weighted_arbitration_unit.sv
// tb/tb_weighted_arbitration_unit.sv - scoreboard bench for weighted_arbitration_unit
module tb_weighted_arbitration_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  requests;
    logic [31:0] weights;
    logic        prio_mode;
    logic        hold;
    logic [7:0]  grants;
    logic [2:0]  grant_idx;
    logic        grant_valid;

    // Expected {grants, grant_idx, grant_valid}, pushed at drive time, popped after the edge.
    logic [11:0] exp_q [$];
    int tests_run    = 0;
    int tests_failed = 0;

    weighted_arbitration_unit #(
        .NUM_CLIENTS(8),
        .WEIGHT_W   (4),
        .CAN_HOLD   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .requests   (requests),
        .weights    (weights),
        .prio_mode  (prio_mode),
        .hold       (hold),
        .grants     (grants),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    always #5 clk = ~clk;

    task automatic apply_reset(input logic [31:0] w);
        @(negedge clk);
        rst_n     = 1'b0;
        requests  = 8'h00;
        hold      = 1'b0;
        prio_mode = 1'b0;
        weights   = w;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        apply_reset({8{4'h1}});
        #1;
        obs = {grants, grant_idx, grant_valid};
        tests_run++;
        if (obs !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_state: grants=%b idx=%0d valid=%b, expected all zero", grants, grant_idx, grant_valid);
        end
    endtask

    task automatic test_equal_weights();
        logic [11:0] exp_t [3] = '{{8'h01, 3'd0, 1'b1}, {8'h02, 3'd1, 1'b1}, {8'h01, 3'd0, 1'b1}};
        logic [11:0] e;
        apply_reset({8{4'h1}});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            requests = 8'h03;
            exp_q.push_back(exp_t[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({grants, grant_idx, grant_valid} !== e) begin
                tests_failed++;
                $display("FAIL equal_weights[%0d]: grants=%b idx=%0d valid=%b, expected grants=%b idx=%0d valid=%b",
                         i, grants, grant_idx, grant_valid, e[11:4], e[3:1], e[0]);
            end
        end
    endtask

    task automatic test_weighted_tenure();
        logic [2:0]  seq [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1};
        logic [11:0] e;
        logic [7:0]  oh;
        apply_reset(32'h0000_0013);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            requests = 8'h03;
            oh = 8'h01 << seq[i];
            exp_q.push_back({oh, seq[i], 1'b1});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({grants, grant_idx, grant_valid} !== e) begin
                tests_failed++;
                $display("FAIL weighted_tenure[%0d]: grants=%b idx=%0d valid=%b, expected grants=%b idx=%0d valid=%b",
                         i, grants, grant_idx, grant_valid, e[11:4], e[3:1], e[0]);
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0]  rq    [7] = '{8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h01, 8'h02};
        logic        hd    [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [11:0] exp_t [7] = '{{8'h04, 3'd2, 1'b1}, {8'h04, 3'd2, 1'b1}, {8'h04, 3'd2, 1'b1},
                                   {8'h04, 3'd2, 1'b1}, {8'h08, 3'd3, 1'b1}, {8'h01, 3'd0, 1'b1},
                                   {8'h02, 3'd1, 1'b1}};
        logic [11:0] e;
        apply_reset({8{4'h1}});
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            requests = rq[i];
            hold     = hd[i];
            exp_q.push_back(exp_t[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({grants, grant_idx, grant_valid} !== e) begin
                tests_failed++;
                $display("FAIL hold[%0d]: grants=%b idx=%0d valid=%b, expected grants=%b idx=%0d valid=%b",
                         i, grants, grant_idx, grant_valid, e[11:4], e[3:1], e[0]);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_hold_no_effect();
        logic [7:0]  rq    [2] = '{8'h01, 8'h02};
        logic [11:0] exp_t [2] = '{{8'h01, 3'd0, 1'b1}, {8'h02, 3'd1, 1'b1}};
        logic [11:0] e;
        apply_reset({8{4'h4}});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            requests = rq[i];
            hold     = 1'b1;
            exp_q.push_back(exp_t[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({grants, grant_idx, grant_valid} !== e) begin
                tests_failed++;
                $display("FAIL hold_no_effect[%0d]: grants=%b idx=%0d valid=%b, expected grants=%b idx=%0d valid=%b",
                         i, grants, grant_idx, grant_valid, e[11:4], e[3:1], e[0]);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_early_release();
        logic [7:0]  rq    [3] = '{8'h21, 8'h21, 8'h20};
        logic [11:0] exp_t [3] = '{{8'h01, 3'd0, 1'b1}, {8'h01, 3'd0, 1'b1}, {8'h20, 3'd5, 1'b1}};
        logic [11:0] e;
        apply_reset({{7{4'h1}}, 4'h4});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            requests = rq[i];
            exp_q.push_back(exp_t[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({grants, grant_idx, grant_valid} !== e) begin
                tests_failed++;
                $display("FAIL early_release[%0d]: grants=%b idx=%0d valid=%b, expected grants=%b idx=%0d valid=%b",
                         i, grants, grant_idx, grant_valid, e[11:4], e[3:1], e[0]);
            end
        end
    endtask

    task automatic test_priority();
        logic [7:0]  rq    [6] = '{8'h86, 8'h86, 8'h86, 8'h86, 8'h00, 8'h86};
        logic        pm    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [11:0] exp_t [6] = '{{8'h02, 3'd1, 1'b1}, {8'h02, 3'd1, 1'b1}, {8'h02, 3'd1, 1'b1},
                                   {8'h02, 3'd1, 1'b1}, {8'h00, 3'd1, 1'b0}, {8'h04, 3'd2, 1'b1}};
        logic [11:0] e;
        apply_reset({8{4'h1}});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            requests  = rq[i];
            prio_mode = pm[i];
            exp_q.push_back(exp_t[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({grants, grant_idx, grant_valid} !== e) begin
                tests_failed++;
                $display("FAIL priority[%0d]: grants=%b idx=%0d valid=%b, expected grants=%b idx=%0d valid=%b",
                         i, grants, grant_idx, grant_valid, e[11:4], e[3:1], e[0]);
            end
        end
        prio_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp_t [3] = '{{8'h01, 3'd0, 1'b1}, {8'h02, 3'd1, 1'b1}, {8'h01, 3'd0, 1'b1}};
        logic [11:0] e;
        apply_reset({8{4'h1}});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) begin
                rst_n = 1'b0;
                #1;
                tests_run++;
                if ({grants, grant_idx, grant_valid} !== 12'h000) begin
                    tests_failed++;
                    $display("FAIL reset_async: grants=%b idx=%0d valid=%b, expected all zero", grants, grant_idx, grant_valid);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
            requests = 8'hFF;
            exp_q.push_back(exp_t[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({grants, grant_idx, grant_valid} !== e) begin
                tests_failed++;
                $display("FAIL reset_mid[%0d]: grants=%b idx=%0d valid=%b, expected grants=%b idx=%0d valid=%b",
                         i, grants, grant_idx, grant_valid, e[11:4], e[3:1], e[0]);
            end
        end
    endtask

    task automatic test_invariants();
        apply_reset(32'h0000_0000);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            requests  = 8'($urandom_range(0, 255));
            weights   = $urandom;
            prio_mode = ($urandom_range(0, 7) == 0);
            hold      = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            tests_run++;
            if (!$onehot0(grants) || (grants[grant_idx] !== grant_valid) || ((|grants) !== grant_valid)) begin
                tests_failed++;
                $display("FAIL invariants[%0d]: grants=%b idx=%0d valid=%b, expected one-hot/zero with grants[idx]==valid",
                         i, grants, grant_idx, grant_valid);
            end
        end
        hold      = 1'b0;
        prio_mode = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        requests  = 8'h00;
        weights   = 32'h0;
        prio_mode = 1'b0;
        hold      = 1'b0;
        test_reset();
        test_equal_weights();
        test_weighted_tenure();
        test_hold();
        test_hold_no_effect();
        test_early_release();
        test_priority();
        test_reset_mid();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
